// File: rtl/instr_fifo.sv
// Instruction queue for the TPU control path: stages an 80-bit instruction
// from three host-written pieces and queues it in a first-word-fall-through FIFO.

package instr_fifo_pkg;
    typedef logic [31:0] word_type;
    typedef logic [15:0] halfword_type;
    typedef logic [79:0] instr_type;
endpackage

module instr_fifo
    import instr_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  word_type     lower_word,
    input  word_type     middle_word,
    input  halfword_type upper_word,
    input  logic [2:0]   write_en,
    output instr_type    data_out,
    input  logic         next_en,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FIFO_DEPTH);

    word_type     lower_q, lower_d;
    word_type     middle_q, middle_d;
    halfword_type upper_q, upper_d;
    logic [2:0]   valid_q, valid_d;

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;

    instr_type mem_q [FIFO_DEPTH];

    word_type     lower_asm;
    word_type     middle_asm;
    halfword_type upper_asm;
    instr_type    assembled;
    logic         complete;
    logic         do_pop;
    logic         can_accept;
    logic         do_push;

    // Pieces strobed this cycle bypass staging so a final piece pushes on its own edge.
    always_comb begin
        lower_asm  = write_en[0] ? lower_word  : lower_q;
        middle_asm = write_en[1] ? middle_word : middle_q;
        upper_asm  = write_en[2] ? upper_word  : upper_q;
        assembled  = {upper_asm, middle_asm, lower_asm};
        complete   = &(valid_q | write_en);
        do_pop     = next_en && (count_q != '0);
        can_accept = (count_q != COUNT_FULL) || do_pop;
        do_push    = complete && can_accept;
    end

    always_comb begin
        lower_d  = lower_asm;
        middle_d = middle_asm;
        upper_d  = upper_asm;
        valid_d  = do_push ? 3'b000 : (valid_q | write_en);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lower_q  <= '0;
            middle_q <= '0;
            upper_q  <= '0;
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            lower_q  <= lower_d;
            middle_q <= middle_d;
            upper_q  <= upper_d;
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is unreset; data_out is masked while empty so stale entries never leak.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= assembled;
        end
    end

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == COUNT_FULL);
        data_out = empty ? '0 : mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_instr_fifo.sv
// Directed scoreboard bench for instr_fifo: a small staging model predicts
// pushes, expected entries queue up and are compared as the head is consumed.

module tb_instr_fifo;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lower_word;
    logic [31:0] middle_word;
    logic [15:0] upper_word;
    logic [2:0]  write_en;
    logic [79:0] data_out;
    logic        next_en;
    logic        empty;
    logic        full;

    logic [79:0] expQ [$];
    logic [31:0] mLo;
    logic [31:0] mMid;
    logic [15:0] mUp;
    logic [2:0]  mValid;

    int checkCount = 0;
    int passCount  = 0;

    instr_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .lower_word  (lower_word),
        .middle_word (middle_word),
        .upper_word  (upper_word),
        .write_en    (write_en),
        .data_out    (data_out),
        .next_en     (next_en),
        .empty       (empty),
        .full        (full)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkState(input string tag);
        logic [79:0] expHead;
        expHead = (expQ.size() > 0) ? expQ[0] : 80'h0;
        checkOutput({tag, "_empty"}, {79'h0, empty}, {79'h0, expQ.size() == 0});
        checkOutput({tag, "_full"},  {79'h0, full},  {79'h0, expQ.size() == DEPTH});
        checkOutput({tag, "_data"},  data_out, expHead);
    endtask

    task automatic clearModel();
        expQ.delete();
        mLo    = '0;
        mMid   = '0;
        mUp    = '0;
        mValid = '0;
    endtask

    // Drives one clock of stimulus, predicts the edge's effect, then checks flags and head.
    task automatic applyStimulus(input string tag, input logic [2:0] we, input logic [31:0] lo,
                                 input logic [31:0] mid, input logic [15:0] up, input logic nxt);
        int          sizeBefore;
        bit          popping;
        bit          pushing;
        logic [79:0] asmd;
        write_en    = we;
        lower_word  = lo;
        middle_word = mid;
        upper_word  = up;
        next_en     = nxt;
        sizeBefore  = expQ.size();
        popping     = nxt && (sizeBefore > 0);
        #1;
        if (popping) checkOutput({tag, "_head"}, data_out, expQ[0]);
        if (we[0]) mLo  = lo;
        if (we[1]) mMid = mid;
        if (we[2]) mUp  = up;
        mValid  = mValid | we;
        pushing = (mValid == 3'b111) && ((sizeBefore < DEPTH) || popping);
        asmd    = {mUp, mMid, mLo};
        @(posedge clk);
        #1;
        if (popping) void'(expQ.pop_front());
        if (pushing) begin
            expQ.push_back(asmd);
            mValid = '0;
        end
        write_en = '0;
        next_en  = 1'b0;
        checkState(tag);
    endtask

    initial begin
        rst         = 1'b1;
        lower_word  = '0;
        middle_word = '0;
        upper_word  = '0;
        write_en    = '0;
        next_en     = 1'b0;
        clearModel();

        // Reset held across two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkState("reset");

        // Piecewise write, then consume
        applyStimulus("lower_only", 3'b001, 32'hAFFEDEAD, 32'h0, 16'h0, 1'b0);
        applyStimulus("idle_gap", 3'b000, 32'h0, 32'h0, 16'h0, 1'b0);
        applyStimulus("middle_only", 3'b010, 32'h0, 32'hDEADDEAD, 16'h0, 1'b0);
        applyStimulus("upper_done", 3'b100, 32'h0, 32'h0, 16'hBA11, 1'b0);
        checkOutput("assembled_value", data_out, 80'hBA11_DEADDEAD_AFFEDEAD);
        applyStimulus("pop_first", 3'b000, 32'h0, 32'h0, 16'h0, 1'b1);
        checkOutput("empty_after_pop", {79'h0, empty}, 80'h1);

        // Fill to capacity with single-strobe pushes
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("fill", 3'b111, 32'h1000_0000 + i, 32'h2000_0000 ^ (i * 7),
                          16'h3000 + 16'(i), 1'b0);
        end
        checkOutput("full_after_fill", {79'h0, full}, 80'h1);

        // 33rd instruction stalls in staging until a pop frees a slot
        applyStimulus("stall", 3'b111, 32'hCAFE_0033, 32'hBEEF_0033, 16'h0033, 1'b0);
        applyStimulus("stall_idle", 3'b000, 32'h0, 32'h0, 16'h0, 1'b0);
        applyStimulus("pop_release", 3'b000, 32'h0, 32'h0, 16'h0, 1'b1);
        checkOutput("full_after_release", {79'h0, full}, 80'h1);

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("drain", 3'b000, 32'h0, 32'h0, 16'h0, 1'b1);
        end
        checkOutput("empty_after_drain", {79'h0, empty}, 80'h1);

        // Last write of a staged piece wins
        applyStimulus("lower_v1", 3'b001, 32'h1, 32'h0, 16'h0, 1'b0);
        applyStimulus("lower_v2", 3'b001, 32'h2, 32'h0, 16'h0, 1'b0);
        applyStimulus("mid_up", 3'b110, 32'h0, 32'h5555_AAAA, 16'h7E57, 1'b0);
        checkOutput("rewrite_lower", {48'h0, data_out[31:0]}, 80'h2);

        // Push and pop on the same edge with one entry queued
        applyStimulus("push_pop", 3'b111, 32'h0BAD_F00D, 32'h1234_5678, 16'h9ABC, 1'b1);
        applyStimulus("pop_last", 3'b000, 32'h0, 32'h0, 16'h0, 1'b1);

        // Asynchronous reset between edges with entries and a partial piece queued
        applyStimulus("pre_rst_a", 3'b111, 32'h0000_00A1, 32'h0000_00A2, 16'h00A3, 1'b0);
        applyStimulus("pre_rst_b", 3'b111, 32'h0000_00B1, 32'h0000_00B2, 16'h00B3, 1'b0);
        applyStimulus("pre_rst_c", 3'b111, 32'h0000_00C1, 32'h0000_00C2, 16'h00C3, 1'b0);
        applyStimulus("pre_rst_partial", 3'b011, 32'h0000_00D1, 32'h0000_00D2, 16'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        clearModel();
        checkState("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("pop_after_rst", 3'b000, 32'h0, 32'h0, 16'h0, 1'b1);
        // Staging was cleared, so a lone upper piece must not push
        applyStimulus("upper_after_rst", 3'b100, 32'h0, 32'h0, 16'h00D3, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
